// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared parameters and types for the instruction fetch controller.
// Holds the bus/opcode widths, the controller state encoding and a
// small helper for the wrapping program counter increment.
package instr_fetch_ctrl_pkg;

    localparam int BUS_WIDTH    = 8;
    localparam int OPCODE_WIDTH = 8;

    // Width of the optional stall counter and its saturation value
    localparam int STALL_CNT_WIDTH = 16;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // PC increment; the result is truncated to BUS_WIDTH so all ones wraps to 0
    function automatic logic [BUS_WIDTH-1:0] pc_incr(input logic [BUS_WIDTH-1:0] a);
        return a + BUS_WIDTH'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller.
// IDLE: program-load port passes writes straight through to the instruction
// memory. FETCH: sequential fetch with stall, jump redirect and halt
// detection. HALT: waits for run to go back to IDLE.
// Optional feature: define FETCH_STALL_COUNT_EN to add the 16-bit stall_cnt
// output counting stalled FETCH cycles (saturating).
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [BUS_WIDTH-1:0]    START_ADDR  = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       stall,
    input  logic                       jump_en,
    input  logic [BUS_WIDTH-1:0]       jump_addr,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [BUS_WIDTH-1:0]       ld_addr,
    input  logic [OPCODE_WIDTH-1:0]    ld_data,
    output logic [BUS_WIDTH-1:0]       mem_addr,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [OPCODE_WIDTH-1:0]    mem_wdata,
    input  logic [OPCODE_WIDTH-1:0]    mem_rdata,
    output logic [OPCODE_WIDTH-1:0]    instr,
    output logic                       instr_valid,
    output logic [BUS_WIDTH-1:0]       pc,
`ifdef FETCH_STALL_COUNT_EN
    output logic [STALL_CNT_WIDTH-1:0] stall_cnt,
`endif
    output logic                       halted
);

    fetch_state_t               state;
    fetch_state_t               state_n;
    logic [BUS_WIDTH-1:0]       pc_n;
    logic [OPCODE_WIDTH-1:0]    instr_n;
    logic                       valid_n;
    logic                       halt_issued;
`ifdef FETCH_STALL_COUNT_EN
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_n;
`endif

    // The halt opcode is issued for one cycle before the state moves to HALT
    assign halt_issued = (state == FETCH) && instr_valid && (instr == HALT_OPCODE);
    assign halted      = (state == HALT);

    // State, PC and issued-instruction registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_STALL_COUNT_EN
            stall_cnt   <= '0;
`endif
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_valid <= valid_n;
`ifdef FETCH_STALL_COUNT_EN
            stall_cnt   <= stall_cnt_n;
`endif
        end
    end

    // Next-state logic plus memory and load-port outputs
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        instr_n   = instr;
        valid_n   = instr_valid;
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
`ifdef FETCH_STALL_COUNT_EN
        stall_cnt_n = stall_cnt;
`endif

        case (state)
            IDLE: begin
                ld_ready = 1'b1;
                valid_n  = 1'b0;
                if (ld_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                end
                if (run) begin
                    state_n = FETCH;
                    pc_n    = START_ADDR;
`ifdef FETCH_STALL_COUNT_EN
                    stall_cnt_n = '0;
`endif
                end
            end

            FETCH: begin
                mem_en = ~stall;
                if (stall) begin
`ifdef FETCH_STALL_COUNT_EN
                    if (stall_cnt != STALL_CNT_MAX) begin
                        stall_cnt_n = stall_cnt + STALL_CNT_WIDTH'(1);
                    end
`endif
                end else if (halt_issued) begin
                    state_n = HALT;
                    valid_n = 1'b0;
                end else if (jump_en) begin
                    pc_n    = jump_addr;
                    valid_n = 1'b0;
                end else begin
                    instr_n = mem_rdata;
                    valid_n = 1'b1;
                    if (mem_rdata != HALT_OPCODE) begin
                        pc_n = pc_incr(pc);
                    end
                end
            end

            HALT: begin
                valid_n = 1'b0;
                if (run) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl: two instances (default START_ADDR
// and START_ADDR = all ones), each with a combinational-read memory model.
module tb_instr_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         failures = 0;

    // Main instance signals
    logic       run, stall, jump_en, ld_valid, ld_ready, mem_en, mem_we, instr_valid, halted;
    logic [7:0] jump_addr, ld_addr, ld_data, mem_addr, mem_wdata, mem_rdata, instr, pc;
    logic [7:0] mem [256];

    // Wrap instance signals
    logic       w_run, w_ld_valid, w_ld_ready, w_mem_en, w_mem_we, w_instr_valid, w_halted;
    logic [7:0] w_ld_addr, w_ld_data, w_mem_addr, w_mem_wdata, w_mem_rdata, w_instr, w_pc;
    logic [7:0] w_mem [256];

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .halted(halted)
    );

    instr_fetch_ctrl #(.START_ADDR(8'hFF)) dut_w (
        .clk(clk), .rst(rst), .run(w_run), .stall(1'b0),
        .jump_en(1'b0), .jump_addr(8'h00),
        .ld_valid(w_ld_valid), .ld_ready(w_ld_ready), .ld_addr(w_ld_addr), .ld_data(w_ld_data),
        .mem_addr(w_mem_addr), .mem_en(w_mem_en), .mem_we(w_mem_we), .mem_wdata(w_mem_wdata),
        .mem_rdata(w_mem_rdata), .instr(w_instr), .instr_valid(w_instr_valid), .pc(w_pc),
        .halted(w_halted)
    );

    // Instruction memories: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (w_mem_en && w_mem_we) w_mem[w_mem_addr] <= w_mem_wdata;
    end
    assign mem_rdata   = mem[mem_addr];
    assign w_mem_rdata = w_mem[w_mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [7:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 8'h00); end
        checks++; if (instr !== 8'h00) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=%h", instr, 8'h00); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ld_ready got=%b exp=1", ld_ready); end
        checks++; if (w_pc !== 8'hFF) begin failures++; $display("[TB] FAIL reset_wrap_pc got=%h exp=%h", w_pc, 8'hFF); end
    endtask

    task automatic test_wrap();
        w_ld_valid = 1'b1; w_ld_addr = 8'hFF; w_ld_data = 8'h11; tick();
        w_ld_addr = 8'h00; w_ld_data = 8'h22; tick();
        w_ld_addr = 8'h01; w_ld_data = 8'h33; tick();
        w_ld_valid = 1'b0;
        w_run = 1'b1; tick(); w_run = 1'b0;
        checks++; if (w_pc !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_start_pc got=%h exp=%h", w_pc, 8'hFF); end
        tick();
        checks++; if (w_instr !== 8'h11 || w_instr_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_instr0 got=%h/%b exp=11/1", w_instr, w_instr_valid); end
        checks++; if (w_pc !== 8'h00) begin failures++; $display("[TB] FAIL wrap_pc0 got=%h exp=%h", w_pc, 8'h00); end
        tick();
        checks++; if (w_instr !== 8'h22 || w_pc !== 8'h01) begin failures++; $display("[TB] FAIL wrap_pc1 got=%h/%h exp=22/01", w_instr, w_pc); end
    endtask

    task automatic test_load_run();
        // combinational pass-through of the first load
        ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 8'h01;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 8'h01) begin
            failures++; $display("[TB] FAIL load_passthru got en=%b we=%b a=%h d=%h exp 1 1 00 01", mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick();
        ld_valid = 1'b0;
        load_word(8'h01, 8'h02);
        load_word(8'h02, 8'h03);
        load_word(8'h10, 8'hA5);
        load_word(8'h11, 8'hA6);
        load_word(8'h12, 8'hA7);
        load_word(8'h30, 8'h00);
        // last load coincides with run
        ld_valid = 1'b1; ld_addr = 8'h03; ld_data = 8'hFF; run = 1'b1;
        tick();
        ld_valid = 1'b0; run = 1'b0;
        checks++; if (mem[3] !== 8'hFF) begin failures++; $display("[TB] FAIL load_with_run got=%h exp=FF", mem[3]); end
        checks++; if (pc !== 8'h00 || ld_ready !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL run_enter got pc=%h rdy=%b v=%b exp 00 0 0", pc, ld_ready, instr_valid);
        end
        // load attempt during FETCH is refused
        ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 8'h77;
        #1;
        checks++; if (ld_ready !== 1'b0 || mem_we !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h00) begin
            failures++; $display("[TB] FAIL fetch_load_refused got rdy=%b we=%b en=%b a=%h exp 0 0 1 00", ld_ready, mem_we, mem_en, mem_addr);
        end
        tick();
        ld_valid = 1'b0;
        checks++; if (instr !== 8'h01 || instr_valid !== 1'b1 || pc !== 8'h01) begin failures++; $display("[TB] FAIL fetch0 got %h/%b/%h exp 01/1/01", instr, instr_valid, pc); end
        tick();
        checks++; if (instr !== 8'h02 || instr_valid !== 1'b1 || pc !== 8'h02) begin failures++; $display("[TB] FAIL fetch1 got %h/%b/%h exp 02/1/02", instr, instr_valid, pc); end
        tick();
        checks++; if (instr !== 8'h03 || instr_valid !== 1'b1 || pc !== 8'h03) begin failures++; $display("[TB] FAIL fetch2 got %h/%b/%h exp 03/1/03", instr, instr_valid, pc); end
        tick();
        checks++; if (instr !== 8'hFF || instr_valid !== 1'b1 || pc !== 8'h03 || halted !== 1'b0) begin
            failures++; $display("[TB] FAIL fetch_halt_issue got %h/%b/%h/%b exp FF/1/03/0", instr, instr_valid, pc, halted);
        end
        tick();
        checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc !== 8'h03 || mem_en !== 1'b0) begin
            failures++; $display("[TB] FAIL halt_state got h=%b v=%b pc=%h en=%b exp 1 0 03 0", halted, instr_valid, pc, mem_en);
        end
        checks++; if (mem[8'h30] !== 8'h00) begin failures++; $display("[TB] FAIL refused_load_written got=%h exp=00", mem[8'h30]); end
        run = 1'b1; tick(); run = 1'b0;
        checks++; if (ld_ready !== 1'b1 || halted !== 1'b0) begin failures++; $display("[TB] FAIL halt_to_idle got rdy=%b h=%b exp 1 0", ld_ready, halted); end
    endtask

    task automatic test_jump_stall();
        run = 1'b1; tick(); run = 1'b0;
        tick();
        checks++; if (instr !== 8'h01 || pc !== 8'h01) begin failures++; $display("[TB] FAIL jump_pre got %h/%h exp 01/01", instr, pc); end
        jump_en = 1'b1; jump_addr = 8'h10;
        tick();
        jump_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || pc !== 8'h10) begin failures++; $display("[TB] FAIL jump_bubble got v=%b pc=%h exp 0 10", instr_valid, pc); end
        tick();
        checks++; if (instr !== 8'hA5 || instr_valid !== 1'b1 || pc !== 8'h11) begin failures++; $display("[TB] FAIL jump_target got %h/%b/%h exp A5/1/11", instr, instr_valid, pc); end
        tick();
        stall = 1'b1; jump_en = 1'b1; jump_addr = 8'h20;
        #1;
        checks++; if (mem_en !== 1'b0) begin failures++; $display("[TB] FAIL stall_mem_en got=%b exp=0", mem_en); end
        tick();
        tick();
        checks++; if (instr !== 8'hA6 || instr_valid !== 1'b1 || pc !== 8'h12) begin failures++; $display("[TB] FAIL stall_jump_hold got %h/%b/%h exp A6/1/12", instr, instr_valid, pc); end
        stall = 1'b0; jump_addr = 8'h03;
        tick();
        jump_en = 1'b0;
        checks++; if (pc !== 8'h03 || instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL jump_to_halt got pc=%h v=%b exp 03 0", pc, instr_valid); end
        tick();
        tick();
        checks++; if (halted !== 1'b1 || pc !== 8'h03) begin failures++; $display("[TB] FAIL jump_halted got h=%b pc=%h exp 1 03", halted, pc); end
        run = 1'b1; tick(); run = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        run = 1'b1; tick(); run = 1'b0;
        tick();
        tick();
        checks++; if (pc !== 8'h02 || instr !== 8'h02) begin failures++; $display("[TB] FAIL midfetch_pre got %h/%h exp 02/02", pc, instr); end
        rst = 1'b1; run = 1'b1; jump_en = 1'b1; jump_addr = 8'h10; ld_valid = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0; jump_en = 1'b0; ld_valid = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b1 || instr_valid !== 1'b0 || pc !== 8'h00 || instr !== 8'h00 || halted !== 1'b0) begin
            failures++; $display("[TB] FAIL midfetch_reset got rdy=%b v=%b pc=%h i=%h h=%b exp 1 0 00 00 0", ld_ready, instr_valid, pc, instr, halted);
        end
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        w_run = 1'b0; w_ld_valid = 1'b0; w_ld_addr = '0; w_ld_data = '0;
        $display("[TB] starting instr_fetch_ctrl bench");
        test_reset();
        test_wrap();
        test_load_run();
        test_jump_stall();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter START_ADDR, default 0: PC value after reset and on each run start.
REQ-002 SHALL have parameter HALT_OPCODE, default all ones (OPCODE_WIDTH bits): fetched opcode that stops sequencing.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: start fetching from START_ADDR.
REQ-006 SHALL have port stall, input, 1 bit: hold PC and output instruction.
REQ-007 SHALL have ports jump_en (input, 1 bit) and jump_addr (input, BUS_WIDTH bits): PC redirect.
REQ-008 SHALL have ports ld_valid (input, 1), ld_ready (output, 1), ld_addr (input, BUS_WIDTH) and ld_data (input, OPCODE_WIDTH): program-load write port.
REQ-009 SHALL have ports mem_addr (output, BUS_WIDTH), mem_en (output, 1), mem_we (output, 1) and mem_wdata (output, OPCODE_WIDTH): instruction-memory control.
REQ-010 SHALL have port mem_rdata, input, OPCODE_WIDTH bits: combinational read data for mem_addr.
REQ-011 SHALL have ports instr (output, OPCODE_WIDTH), instr_valid (output, 1), pc (output, BUS_WIDTH) and halted (output, 1).

Function
REQ-012 SHALL implement states IDLE, FETCH and HALT.
REQ-013 In IDLE, ld_ready SHALL be 1; a cycle with ld_valid=1 SHALL drive mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in that same cycle (combinational pass-through).
REQ-014 In IDLE, run=1 SHALL move to FETCH with pc=START_ADDR; if run and ld_valid are high together, the load completes and run takes effect in the same edge.
REQ-015 In FETCH, ld_ready SHALL be 0; loads are refused, and mem_we=0, mem_en=~stall, mem_addr=pc.
REQ-016 In FETCH without stall, the next edge SHALL register instr<=mem_rdata and instr_valid<=1 (one-cycle latency), then pc<=pc+1 modulo 2**BUS_WIDTH (wrap from all ones to 0).
REQ-017 stall=1 SHALL hold pc, instr and instr_valid unchanged, and stall SHALL have priority over jump_en.
REQ-018 jump_en=1 without stall SHALL set pc<=jump_addr and instr_valid<=0 for that edge, so no instruction is issued in the redirect cycle.
REQ-019 A fetched opcode equal to HALT_OPCODE SHALL be issued with instr_valid=1, then move to HALT and leave pc pointing at the halt address.
REQ-020 In HALT, halted=1, instr_valid=0, mem_en=0; run=1 SHALL return to IDLE (ld_ready=1) on the next edge.
REQ-021 Outside IDLE, mem_we SHALL never be 1.

Reset
REQ-022 rst=1 SHALL, regardless of state, force on the next edge: state IDLE, pc=START_ADDR, instr=0, instr_valid=0, halted=0.
REQ-023 rst SHALL take priority over run, jump_en, stall and ld_valid.

Configuration
REQ-024 With macro FETCH_STALL_COUNT_EN defined, the block SHALL add output stall_cnt (16 bits), counting FETCH cycles with stall=1, saturating at 0xFFFF, cleared by rst and on entry to FETCH.
REQ-025 Without FETCH_STALL_COUNT_EN, stall_cnt and its logic SHALL be absent.

Structure
REQ-026 BUS_WIDTH, OPCODE_WIDTH and the state enum typedef SHALL live in the shared params header/package.
REQ-027 The block SHALL be a single module with no sub-modules; the memory is instantiated by the parent.

Verification
REQ-028 Load then run: load addr0..2 = 0x1,0x2,0x3 with addr3=HALT_OPCODE, then pulse run -> instr 0x1,0x2,0x3,HALT on consecutive cycles, then halted=1 with pc=3.
REQ-029 Jump: jump_en with jump_addr=0x10 during FETCH -> one cycle instr_valid=0, next instr=mem[0x10].
REQ-030 Stall plus jump together -> pc, instr and instr_valid frozen and the jump is ignored.
REQ-031 Wrap: START_ADDR=2**BUS_WIDTH-1 with non-halt opcodes -> pc goes from all ones to 0.
REQ-032 rst asserted mid-FETCH -> next cycle IDLE, instr_valid=0, ld_ready=1, pc=START_ADDR.
REQ-033 ld_valid during FETCH -> ld_ready=0 and mem_we stays 0.
